// File: rtl/zddaq_b_acq_pkg.sv
// Shared types and bit positions for the acquisition sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zddaq_b_acq_pkg;

  // Sequencer states; encodings double as the status state code
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } acq_state_t;

  // ctrl_word bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_TRIG_EN = 2;
  localparam int CTRL_CONT    = 3;

  // status_word bit positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_CFG_ERR   = 3;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_FRAME_LSB = 8;
  localparam int FRAME_W        = 24;

  // State codes as reported in status_word[7:4]
  localparam logic [3:0] CODE_IDLE      = 4'd0;
  localparam logic [3:0] CODE_WAIT_TRIG = 4'd1;
  localparam logic [3:0] CODE_RUN       = 4'd2;
  localparam logic [3:0] CODE_DONE      = 4'd3;

  function automatic logic [3:0] state_code(input acq_state_t s);
    logic [3:0] code;
    code = CODE_IDLE;
    case (s)
      ST_IDLE:      code = CODE_IDLE;
      ST_WAIT_TRIG: code = CODE_WAIT_TRIG;
      ST_RUN:       code = CODE_RUN;
      ST_DONE:      code = CODE_DONE;
      default:      code = CODE_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/zddaq_b_sync_edge.sv
// Synchronises an asynchronous level and flags its rising edge.
// Latency: level appears C_SYNC_STAGES cycles after input; rise pulse in that same cycle.
// Backpressure: none; free-running, rise pulse lasts one cycle.
module zddaq_b_sync_edge #(
  parameter int C_SYNC_STAGES = 2
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [C_SYNC_STAGES-1:0] r_sync;
  logic                     r_prev;

  // Shift the async input through the flop chain and remember the last level
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < C_SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[C_SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[C_SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;

endmodule

// File: rtl/zddaq_b_acq_sequencer.sv
// Frame acquisition sequencer: paces sample requests to an ADC capture stage.
// Latency: first request P cycles after RUN entry, one request per period tick.
// Backpressure: request held until smp_ready; ticks hitting a pending request set overrun.
module zddaq_b_acq_sequencer
  import zddaq_b_acq_pkg::*;
#(
  parameter int C_CNT_WIDTH   = 32,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [31:0]            ctrl_word,
  input  logic [C_CNT_WIDTH-1:0] cfg_count,
  input  logic [C_CNT_WIDTH-1:0] cfg_period,
  input  logic                   ext_trig,
  output logic                   smp_valid,
  output logic [C_CNT_WIDTH-1:0] smp_index,
  input  logic                   smp_ready,
  output logic [31:0]            status_word,
  output logic                   done_irq
);

  localparam logic [C_CNT_WIDTH-1:0] LP_ONE = 1;

  acq_state_t             r_state;
  acq_state_t             w_state_nxt;
  logic                   r_armed;
  logic                   r_start_q;
  logic [C_CNT_WIDTH-1:0] r_cnt_lat;
  logic [C_CNT_WIDTH-1:0] r_per_lat;
  logic                   r_cont;
  logic [C_CNT_WIDTH-1:0] r_div;
  logic [C_CNT_WIDTH-1:0] r_smp_cnt;
  logic                   r_smp_vld;
  logic [C_CNT_WIDTH-1:0] r_smp_idx;
  logic                   r_done;
  logic                   r_overrun;
  logic                   r_cfg_err;
  logic [FRAME_W-1:0]     r_frame_cnt;
  logic                   r_done_irq;

  logic                   w_abort;
  logic                   w_start_edge;
  logic                   w_cfg_ok;
  logic                   w_trig_lvl;
  logic                   w_trig_rise;
  logic [C_CNT_WIDTH-1:0] w_per_m1;
  logic                   w_tick;
  logic                   w_accept;
  logic [C_CNT_WIDTH-1:0] w_cnt_inc;
  logic                   w_frame_end;
  logic                   w_issue;
  logic [C_CNT_WIDTH-1:0] w_issue_idx;
  logic                   w_overrun_evt;
  logic                   w_unused_bits;

  zddaq_b_sync_edge #(
    .C_SYNC_STAGES(C_SYNC_STAGES)
  ) u_trig_sync (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .i_async (ext_trig),
    .o_level (w_trig_lvl),
    .o_rise  (w_trig_rise)
  );

  // r_armed suppresses a start edge in the first cycle after reset
  assign w_abort      = ctrl_word[CTRL_ABORT];
  assign w_start_edge = r_armed & ctrl_word[CTRL_START] & ~r_start_q;
  assign w_cfg_ok     = (cfg_count != '0);

  // A latched period of zero behaves like one
  assign w_per_m1    = (r_per_lat == '0) ? '0 : (r_per_lat - LP_ONE);
  assign w_tick      = (r_state == ST_RUN) && (r_div == w_per_m1);
  assign w_accept    = r_smp_vld && smp_ready;
  assign w_cnt_inc   = r_smp_cnt + LP_ONE;
  assign w_frame_end = w_accept && (w_cnt_inc == r_cnt_lat);

  // A tick becomes a request if the slot is free or being freed this cycle,
  // unless this acceptance ends a single-shot frame
  assign w_issue       = w_tick && (!r_smp_vld || w_accept) && !(w_frame_end && !r_cont);
  assign w_issue_idx   = !w_accept ? r_smp_cnt : (w_frame_end ? '0 : w_cnt_inc);
  assign w_overrun_evt = w_tick && r_smp_vld && !smp_ready;

  assign w_unused_bits = ^{ctrl_word[31:4], w_trig_lvl};

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection; abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge && w_cfg_ok) begin
            w_state_nxt = ctrl_word[CTRL_TRIG_EN] ? ST_WAIT_TRIG : ST_RUN;
          end
        end
        ST_WAIT_TRIG: begin
          if (w_trig_rise) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_frame_end && !r_cont) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: config latch, divider, request handshake, counters and flags
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_armed     <= 1'b0;
      r_start_q   <= 1'b0;
      r_cnt_lat   <= '0;
      r_per_lat   <= '0;
      r_cont      <= 1'b0;
      r_div       <= '0;
      r_smp_cnt   <= '0;
      r_smp_vld   <= 1'b0;
      r_smp_idx   <= '0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_frame_cnt <= '0;
      r_done_irq  <= 1'b0;
    end else begin
      r_armed    <= 1'b1;
      r_start_q  <= ctrl_word[CTRL_START];
      r_done_irq <= 1'b0;
      if (w_abort) begin
        r_smp_vld <= 1'b0;
        r_smp_idx <= '0;
        r_smp_cnt <= '0;
        r_div     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_edge) begin
              if (w_cfg_ok) begin
                r_cnt_lat <= cfg_count;
                r_per_lat <= cfg_period;
                r_cont    <= ctrl_word[CTRL_CONT];
                r_div     <= '0;
                r_smp_cnt <= '0;
                r_done    <= 1'b0;
                r_overrun <= 1'b0;
                r_cfg_err <= 1'b0;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end
          end
          ST_WAIT_TRIG: begin
            r_div <= '0;
          end
          ST_RUN: begin
            r_div <= w_tick ? '0 : (r_div + LP_ONE);
            if (w_accept) begin
              if (w_frame_end) begin
                r_smp_cnt   <= '0;
                r_frame_cnt <= r_frame_cnt + 1'b1;
                r_done_irq  <= 1'b1;
                if (!r_cont) begin
                  r_done <= 1'b1;
                end
              end else begin
                r_smp_cnt <= w_cnt_inc;
              end
            end
            if (w_issue) begin
              r_smp_vld <= 1'b1;
              r_smp_idx <= w_issue_idx;
            end else if (w_accept) begin
              r_smp_vld <= 1'b0;
            end
            if (w_overrun_evt) begin
              r_overrun <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign smp_valid   = r_smp_vld;
  assign smp_index   = r_smp_idx;
  assign done_irq    = r_done_irq;
  assign status_word = {r_frame_cnt, state_code(r_state), r_cfg_err, r_overrun, r_done,
                        (r_state != ST_IDLE)};

endmodule

// File: tb/tb_zddaq_b_acq_sequencer.sv
// Directed bench for the acquisition sequencer: a cycle table for a full frame,
// then hand-written sequences for config error, overrun, trigger wait,
// continuous mode with abort, and reset in mid-run.
module tb_zddaq_b_acq_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] ctrl_word;
  logic [31:0] cfg_count;
  logic [31:0] cfg_period;
  logic        ext_trig;
  logic        smp_valid;
  logic [31:0] smp_index;
  logic        smp_ready;
  logic [31:0] status_word;
  logic        done_irq;

  int n_chk  = 0;
  int n_fail = 0;

  zddaq_b_acq_sequencer #(
    .C_CNT_WIDTH  (32),
    .C_SYNC_STAGES(2)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .ctrl_word  (ctrl_word),
    .cfg_count  (cfg_count),
    .cfg_period (cfg_period),
    .ext_trig   (ext_trig),
    .smp_valid  (smp_valid),
    .smp_index  (smp_index),
    .smp_ready  (smp_ready),
    .status_word(status_word),
    .done_irq   (done_irq)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] ctrl;
    logic        vld;
    logic [31:0] idx;
    logic [31:0] st;
    logic        irq;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int          idx_q[$];
    int          irq_n;
    int          n;
    int          bad;
    logic [31:0] exp_pat[6];

    ARESET     = 1'b1;
    ctrl_word  = 32'h0;
    cfg_count  = 32'd4;
    cfg_period = 32'd3;
    ext_trig   = 1'b0;
    smp_ready  = 1'b1;

    // Scenario 1 table: count=4, period=3, ready=1. Start held two cycles.
    tbl[0]  = '{32'h1, 1'b0, 32'd0, 32'h21,  1'b0};
    tbl[1]  = '{32'h1, 1'b0, 32'd0, 32'h21,  1'b0};
    tbl[2]  = '{32'h0, 1'b0, 32'd0, 32'h21,  1'b0};
    tbl[3]  = '{32'h0, 1'b1, 32'd0, 32'h21,  1'b0};
    tbl[4]  = '{32'h0, 1'b0, 32'd0, 32'h21,  1'b0};
    tbl[5]  = '{32'h0, 1'b0, 32'd0, 32'h21,  1'b0};
    tbl[6]  = '{32'h0, 1'b1, 32'd1, 32'h21,  1'b0};
    tbl[7]  = '{32'h0, 1'b0, 32'd0, 32'h21,  1'b0};
    tbl[8]  = '{32'h0, 1'b0, 32'd0, 32'h21,  1'b0};
    tbl[9]  = '{32'h0, 1'b1, 32'd2, 32'h21,  1'b0};
    tbl[10] = '{32'h0, 1'b0, 32'd0, 32'h21,  1'b0};
    tbl[11] = '{32'h0, 1'b0, 32'd0, 32'h21,  1'b0};
    tbl[12] = '{32'h0, 1'b1, 32'd3, 32'h21,  1'b0};
    tbl[13] = '{32'h0, 1'b0, 32'd0, 32'h133, 1'b1};
    tbl[14] = '{32'h0, 1'b0, 32'd0, 32'h102, 1'b0};
    tbl[15] = '{32'h0, 1'b0, 32'd0, 32'h102, 1'b0};

    // Reset state
    step();
    step();
    chk("rst_status", status_word, 32'h0);
    chk("rst_valid", {31'd0, smp_valid}, 32'd0);
    chk("rst_irq", {31'd0, done_irq}, 32'd0);
    ARESET = 1'b0;
    step();

    // Scenario 1
    for (int i = 0; i < 16; i++) begin
      ctrl_word = tbl[i].ctrl;
      step();
      chk($sformatf("s1_vld[%0d]", i), {31'd0, smp_valid}, {31'd0, tbl[i].vld});
      if (tbl[i].vld) chk($sformatf("s1_idx[%0d]", i), smp_index, tbl[i].idx);
      chk($sformatf("s1_status[%0d]", i), status_word, tbl[i].st);
      chk($sformatf("s1_irq[%0d]", i), {31'd0, done_irq}, {31'd0, tbl[i].irq});
    end

    // Scenario 2: zero count is rejected, then a valid start clears the error
    cfg_count = 32'd0;
    ctrl_word = 32'h1;
    step();
    chk("s2_cfg_err", status_word, 32'h10A);
    ctrl_word = 32'h0;
    step();
    cfg_count  = 32'd2;
    cfg_period = 32'd2;
    ctrl_word  = 32'h1;
    step();
    chk("s2_restart", status_word, 32'h121);
    ctrl_word = 32'h0;
    idx_q.delete();
    irq_n = 0;
    n = 0;
    while (status_word[7:4] != 4'd0 && n < 40) begin
      if (smp_valid) idx_q.push_back(int'(smp_index));
      if (done_irq) irq_n++;
      step();
      n++;
    end
    chk("s2_timeout", n, (n < 40) ? n : 0);
    chk("s2_nsmp", idx_q.size(), 2);
    if (idx_q.size() == 2) begin
      chk("s2_idx0", idx_q[0], 0);
      chk("s2_idx1", idx_q[1], 1);
    end
    chk("s2_irq", irq_n, 1);
    chk("s2_final", status_word, 32'h202);

    // Scenario 3: period 1, ready low for 3 further ticks -> overrun
    cfg_count  = 32'd4;
    cfg_period = 32'd1;
    smp_ready  = 1'b0;
    ctrl_word  = 32'h1;
    step();
    ctrl_word = 32'h0;
    step();
    chk("s3_first_vld", {31'd0, smp_valid}, 32'd1);
    chk("s3_first_idx", smp_index, 32'd0);
    chk("s3_no_ovr_yet", {31'd0, status_word[2]}, 32'd0);
    step();
    step();
    step();
    chk("s3_hold_vld", {31'd0, smp_valid}, 32'd1);
    chk("s3_hold_idx", smp_index, 32'd0);
    chk("s3_overrun", {31'd0, status_word[2]}, 32'd1);
    smp_ready = 1'b1;
    idx_q.delete();
    n = 0;
    while (status_word[7:4] != 4'd0 && n < 20) begin
      if (smp_valid) idx_q.push_back(int'(smp_index));
      step();
      n++;
    end
    chk("s3_nacc", idx_q.size(), 4);
    for (int i = 0; i < idx_q.size() && i < 4; i++) chk($sformatf("s3_idx[%0d]", i), idx_q[i], i);
    chk("s3_final", status_word, 32'h306);

    // Scenario 4: wait for external trigger
    cfg_count  = 32'd1;
    cfg_period = 32'd1;
    ctrl_word  = 32'h5;
    step();
    chk("s4_wait", status_word, 32'h311);
    ctrl_word = 32'h4;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (smp_valid || status_word[7:4] != 4'd1) bad++;
    end
    chk("s4_idle_wait", bad, 0);
    ext_trig = 1'b1;
    step();
    ext_trig = 1'b0;
    n = 1;
    while (status_word[7:4] != 4'd2 && n < 10) begin
      step();
      n++;
    end
    chk("s4_trig_lat", (n <= 4) ? 32'd1 : 32'd0, 32'd1);
    n = 0;
    while (status_word[7:4] != 4'd0 && n < 20) begin
      step();
      n++;
    end
    chk("s4_final", status_word, 32'h402);
    ctrl_word = 32'h0;
    step();

    // Scenario 5: continuous frames then abort
    exp_pat = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
    cfg_count  = 32'd2;
    cfg_period = 32'd2;
    ctrl_word  = 32'h9;
    step();
    ctrl_word = 32'h8;
    idx_q.delete();
    irq_n = 0;
    n = 0;
    while (irq_n < 3 && n < 200) begin
      if (smp_valid) idx_q.push_back(int'(smp_index));
      step();
      if (done_irq) irq_n++;
      n++;
    end
    chk("s5_irqs", irq_n, 3);
    chk("s5_nidx", idx_q.size(), 6);
    for (int i = 0; i < idx_q.size() && i < 6; i++) chk($sformatf("s5_idx[%0d]", i), idx_q[i], exp_pat[i]);
    chk("s5_running", status_word, 32'h721);
    n = 0;
    while (!smp_valid && n < 10) begin
      step();
      n++;
    end
    chk("s5_vld_before_abort", {31'd0, smp_valid}, 32'd1);
    ctrl_word = 32'hA;
    step();
    chk("s5_abort_state", {24'd0, status_word[7:0]}, 32'h0);
    chk("s5_abort_vld", {31'd0, smp_valid}, 32'd0);
    ctrl_word = 32'h0;
    step();

    // Scenario 6: reset mid-run, start held through reset release
    cfg_count  = 32'd4;
    cfg_period = 32'd1;
    smp_ready  = 1'b0;
    ctrl_word  = 32'h1;
    step();
    step();
    chk("s6_pre_vld", {31'd0, smp_valid}, 32'd1);
    ARESET = 1'b1;
    step();
    chk("s6_rst_vld", {31'd0, smp_valid}, 32'd0);
    chk("s6_rst_idx", smp_index, 32'd0);
    chk("s6_rst_status", status_word, 32'd0);
    chk("s6_rst_irq", {31'd0, done_irq}, 32'd0);
    ARESET = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (smp_valid || status_word != 32'd0) bad++;
    end
    chk("s6_no_acq", bad, 0);
    ctrl_word = 32'h0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/zddaq_b_acq_sequencer.md
ZDDAQ_B_ACQ_SEQUENCER -- requirements
Module: zddaq_b_acq_sequencer

Interface
REQ-001 Parameter C_CNT_WIDTH, default 32: width of the sample-count, period and index fields.
REQ-002 Parameter C_SYNC_STAGES, default 2: synchroniser depth for ext_trig.
REQ-003 ACLK  in  1  single clock; all logic is rising-edge.
REQ-004 ARESET  in  1  reset, synchronous and active-high.
REQ-005 ctrl_word  in  32  system_ctrl register 0. Bit0 start, bit1 abort (level), bit2 ext_trig_en, bit3 continuous.
REQ-006 cfg_count  in  C_CNT_WIDTH  system_ctrl register 1: samples per frame.
REQ-007 cfg_period  in  C_CNT_WIDTH  system_ctrl register 2: ACLK cycles per sample tick.
REQ-008 ext_trig  in  1  asynchronous external trigger.
REQ-009 smp_valid  out  1  sample request valid.
REQ-010 smp_index  out  C_CNT_WIDTH  index of the requested sample within the frame.
REQ-011 smp_ready  in  1  ADC capture stage accepts the request.
REQ-012 status_word  out  32  to system_ctrl register 3. Bit0 busy, bit1 done, bit2 overrun, bit3 cfg_err, bits[7:4] state code, bits[31:8] frame count mod 2^24.
REQ-013 done_irq  out  1  one-cycle pulse at frame completion.

Function
REQ-014 Start SHALL be the rising edge of ctrl_word[0], taken against a registered copy; level-high start SHALL NOT retrigger.
REQ-015 The FSM SHALL have four states: IDLE=0, WAIT_TRIG=1, RUN=2, DONE=3. The state code SHALL appear in status_word[7:4].
REQ-016 IDLE, on start with cfg_count≠0: SHALL latch cfg_count, cfg_period and the ctrl bits. It SHALL clear done, overrun and cfg_err. The next state SHALL be WAIT_TRIG if ext_trig_en, else RUN.
REQ-017 IDLE, on start with cfg_count=0: SHALL stay in IDLE and set cfg_err (sticky until the next valid start).
REQ-018 WAIT_TRIG: ext_trig SHALL pass through C_SYNC_STAGES flops. A synchronised rising edge SHALL move the FSM to RUN on the next cycle.
REQ-019 RUN: the divider SHALL count 0..P-1 and issue a tick at P-1, where P is the latched period. A latched period of 0 SHALL be treated as 1. The first tick SHALL come P cycles after RUN entry.
REQ-020 A tick with smp_valid low SHALL assert smp_valid on the next cycle, with smp_index equal to the current sample counter.
REQ-021 smp_valid and smp_index SHALL hold stable until the cycle smp_valid&&smp_ready.
REQ-022 A tick arriving while smp_valid is high and not accepted that cycle SHALL set overrun (sticky). The tick SHALL be dropped and not counted.
REQ-023 A tick arriving in the same cycle as an acceptance SHALL be issued as a new request on the next cycle (back-to-back).
REQ-024 On acceptance the sample counter SHALL increment. When it reaches the latched count: non-continuous SHALL go to DONE; continuous SHALL wrap the counter to 0, increment the frame count, pulse done_irq and stay in RUN.
REQ-025 DONE SHALL last one cycle: done_irq=1, done set (sticky until the next start), frame count incremented, then IDLE.
REQ-026 Abort (ctrl_word[1]=1) in any state SHALL force IDLE on the next cycle. It SHALL drop smp_valid (sanctioned exception to the hold rule) and clear the counters. Sticky flags SHALL be kept. Abort SHALL have priority over start and tick.
REQ-027 busy SHALL equal (state≠IDLE).

Reset
REQ-028 While ARESET is high at a clock edge, the following SHALL be 0: state=IDLE, smp_valid, smp_index, done_irq, all status bits, frame count, counters, synchroniser flops and the start-edge register.
REQ-029 A start bit already high when reset releases SHALL NOT be seen as an edge. The edge register SHALL load ctrl_word[0] in the first cycle after reset.

Structure
REQ-030 A package zddaq_b_acq_pkg SHALL hold the state enum, the ctrl/status bit-position constants and the state-code values.
REQ-031 The ext_trig synchroniser SHALL be one sub-module, zddaq_b_sync_edge. Parameters: C_SYNC_STAGES. Outputs: synchronised level and rising-edge pulse.

Verification
REQ-032 Scenario 1: cfg_count=4, cfg_period=3, start, smp_ready=1 -> indices 0,1,2,3 three cycles apart, then done_irq once, status done=1, frame count=1.
REQ-033 Scenario 2: cfg_count=0, start -> state stays IDLE, cfg_err=1. Then cfg_count=2 with start -> cfg_err=0 and 2 samples issued.
REQ-034 Scenario 3: cfg_period=1, smp_ready held low for 3 ticks -> overrun=1, smp_index stays 0, and 4 accepted samples still complete the frame.
REQ-035 Scenario 4: ext_trig_en=1, start, no trigger for 50 cycles -> state=1, no smp_valid. Trigger pulse -> RUN within C_SYNC_STAGES+2 cycles.
REQ-036 Scenario 5: continuous=1, cfg_count=2, 3 frames -> 3 done_irq pulses and index pattern 0,1,0,1,0,1. Abort -> IDLE next cycle, smp_valid=0.
REQ-037 Scenario 6: ARESET in the middle of RUN with smp_valid=1 -> all outputs 0 the next cycle. Start held high through reset release -> no acquisition.
